// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply and restoring divide, one bit per clock.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd, r_rd_q;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb, r_pend, r_result;
    logic                r_neg_q, r_neg_r;

    logic                w_accept, w_is_div, w_a_sgn, w_b_sgn;
    logic                w_a_neg, w_b_neg, w_div0, w_ovf, w_last;
    logic [XLEN-1:0]     w_a_abs, w_b_abs, w_spec;
    logic [XLEN:0]       w_sum, w_sh, w_diff;
    logic [2*XLEN:0]     w_mul_ext;
    logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_step, w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_final;

    assign w_is_div = funct3_i[2];
    assign w_a_sgn  = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_b_sgn  = (funct3_i == 3'b001) ||
                      (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_a_neg  = w_a_sgn & rs1_data_i[XLEN-1];
    assign w_b_neg  = w_b_sgn & rs2_data_i[XLEN-1];
    assign w_a_abs  = w_a_neg ? -rs1_data_i : rs1_data_i;
    assign w_b_abs  = w_b_neg ? -rs2_data_i : rs2_data_i;
    assign w_div0   = w_is_div & (rs2_data_i == '0);
    assign w_ovf    = w_is_div & ~funct3_i[0] &
                      (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &
                      (rs2_data_i == '1);
    assign w_spec   = w_div0 ? (funct3_i[1] ? rs1_data_i : '1)
                             : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;
    assign w_last   = (r_cnt == CNT_W'(XLEN-1));

    // Multiply: conditional add into the upper half, carry kept for the shift
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
    assign w_mul_ext = r_acc[0] ? {w_sum, r_acc[XLEN-1:0]} : {1'b0, r_acc};
    assign w_mul_nxt = w_mul_ext[2*XLEN:1];

    // Divide: remainder in the upper half, quotient shifts in from the bottom
    assign w_sh      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_diff    = w_sh - {1'b0, r_opb};
    assign w_div_nxt = w_diff[XLEN]
                     ? {w_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                     : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_step = r_funct3[2] ? w_div_nxt : w_mul_nxt;
    assign w_prod = r_neg_q ? -w_step : w_step;
    assign w_quo  = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem  = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_rem;
        unique case (1'b1)
            (r_funct3 == 3'b000): w_final = w_prod[XLEN-1:0];
            (r_funct3[2] == 1'b0 && r_funct3 != 3'b000):
                w_final = w_prod[2*XLEN-1:XLEN];
            (r_funct3[2:1] == 2'b10): w_final = w_quo;
            (r_funct3[2:1] == 2'b11): w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        stall_o  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        result_o = r_result;
        rd_o     = r_rd_q;
        case (r_state)
            S_IDLE: begin
                stall_o = start_i & ~flush_i;
                if (w_accept)
                    w_next = (w_div0 | w_ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                stall_o = ~flush_i;
                busy_o  = 1'b1;
                if (flush_i)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy_o   = 1'b1;
                done_o   = ~flush_i;
                result_o = r_pend;
                rd_o     = r_rd;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_rd_q   <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_pend   <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= funct3_i;
            r_rd     <= rd_i;
            r_acc    <= {{XLEN{1'b0}}, w_a_abs};
            r_opb    <= w_b_abs;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_pend   <= w_spec;
        end else if (r_state == S_CALC && !flush_i) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_step;
            if (w_last) r_pend <= w_final;
        end else if (r_state == S_DONE && !flush_i) begin
            r_result <= r_pend;
            r_rd_q   <= r_rd;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
        .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_i(rd), .flush_i(flush),
        .stall_o(stall), .busy_o(busy), .done_o(done),
        .result_o(result), .rd_o(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op and wait for done_o; counts stalled cycles including the accept cycle.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp,
                          input int exp_stalls);
        int n;
        bit seen;
        @(negedge clk);
        funct3 = f; rs1 = a; rs2 = b; rd = r; start = 1'b1;
        #1;
        n = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall) n++;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(exp_stalls));
        check({tag, "_res"}, result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(r));
        check({tag, "_stall_in_done"}, 32'(stall), 32'd0);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int pulses;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul",   3'b000, 32'h7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
        run_op("mulh",  3'b001, 32'h7, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFFF, 33);
        run_op("mulhu", 3'b011, 32'h7, 32'hFFFFFFFD, 5'd3, 32'h00000006, 33);
        run_op("div",   3'b100, 32'hFFFFFFEC, 32'd6, 5'd4, 32'hFFFFFFFD, 33);
        run_op("rem",   3'b110, 32'hFFFFFFEC, 32'd6, 5'd5, 32'hFFFFFFFE, 33);
        run_op("divu",  3'b101, 32'hFFFFFFEC, 32'd6, 5'd6, 32'h2AAAAAA7, 33);
        run_op("remu",  3'b111, 32'hFFFFFFEC, 32'd6, 5'd7, 32'h00000002, 33);
        run_op("div0",  3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFFFFFF, 1);
        run_op("rem0",  3'b110, 32'd5, 32'd0, 5'd9, 32'h00000005, 1);
        run_op("divov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10,
               32'h80000000, 1);
        run_op("remov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11,
               32'h00000000, 1);

        // Back-to-back: start held high through DONE
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd11; rd = 5'd12; start = 1'b1;
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd13;
        pulses = 0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_res", result, 32'd99);
        check("b2b_first_rd", 32'(rd_out), 32'd12);
        pulses += done ? 1 : 0;
        @(negedge clk);
        check("b2b_accept_stall", 32'(stall), 32'd1);
        check("b2b_accept_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (result !== 32'd99 || rd_out !== 5'd12)
                check("b2b_hold", result, 32'd99);
            @(negedge clk);
        end
        pulses += done ? 1 : 0;
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_second_res", result, 32'd14);
        check("b2b_second_rd", 32'(rd_out), 32'd13);

        // Flush at CALC cycle 10
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5; rd = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            pulses += done ? 1 : 0;
            @(negedge clk);
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_res_kept", result, 32'd14);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        funct3 = 3'b001; rs1 = 32'd123; rs2 = 32'd456; rd = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_res", result, 32'd0);
        check("arst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("mul3x4", 3'b000, 32'd3, 32'd4, 5'd22, 32'h0000000C, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
